// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns core MemRead/MemWrite into one handshaked bus
// transaction, stalls the core meanwhile, and flags misaligned accesses and bus timeouts.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [31:0]       r_bus_addr;
    logic [3:0]        r_bus_be;
    logic [31:0]       r_bus_wdata;
    logic [1:0]        r_off;
    logic [2:0]        r_funct3;
    logic [31:0]       r_rdata;
    logic              r_rdata_valid;
    logic              r_misalign;
    logic              r_timeout;

    logic              w_access;
    logic              w_misalign;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_ext;

    assign w_access = mem_read_i | mem_write_i;

    // Alignment check, byte enables and store-lane replication for the incoming access
    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_misalign = addr_i[0];
                w_be       = 4'b0011 << addr_i[1:0];
                w_wdata    = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                w_misalign = |addr_i[1:0];
            end
            default: begin
                w_misalign = 1'b1;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returned read word
    always_comb begin
        w_byte = bus_rdata_i[7:0];
        case (r_off)
            2'd0:    w_byte = bus_rdata_i[7:0];
            2'd1:    w_byte = bus_rdata_i[15:8];
            2'd2:    w_byte = bus_rdata_i[23:16];
            default: w_byte = bus_rdata_i[31:24];
        endcase
        w_half = r_off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (r_funct3[1:0])
            2'b00:   w_load_ext = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = {{16{~r_funct3[2] & w_half[15]}}, w_half};
            default: w_load_ext = bus_rdata_i;
        endcase
    end

    // Sequencer; pulses default low and are raised only on the cycle a state is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_be      <= '0;
            r_bus_wdata   <= '0;
            r_off         <= '0;
            r_funct3      <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_timeout     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                            r_state    <= ERR;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_write_i;
                            r_bus_addr  <= {addr_i[31:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                            r_off       <= addr_i[1:0];
                            r_funct3    <= funct3_i;
                            r_cnt       <= '0;
                            r_state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus_ack_i) begin
                        r_bus_req <= 1'b0;
                        r_state   <= DONE;
                        if (!r_bus_we) begin
                            r_rdata       <= w_load_ext;
                            r_rdata_valid <= 1'b1;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_bus_req <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= ERR;
                    end
                end
                DONE:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stall must fall with reset even while the core still asserts a request
    assign stall_o = rst_n & (((r_state == IDLE) & w_access) | (r_state == REQ));

    assign bus_req_o     = r_bus_req;
    assign bus_we_o      = r_bus_we;
    assign bus_addr_o    = r_bus_addr;
    assign bus_be_o      = r_bus_be;
    assign bus_wdata_o   = r_bus_wdata;
    assign rdata_o       = r_rdata;
    assign rdata_valid_o = r_rdata_valid;
    assign misalign_o    = r_misalign;
    assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, misalignment, timeout and mid-transaction reset.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, misalign_o, timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    // Per-access observations gathered by run_access
    int          n_req, n_stall, n_valid;
    logic        s_mis, s_to, s_stable, s_done, s_post_busy;
    logic [31:0] s_rdata, snap_addr, snap_wdata;
    logic [3:0]  snap_be;
    logic        snap_we;

    lsu_ctrl #(.TIMEOUT(15)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_be_o      (bus_be_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_ack_i     (bus_ack_i),
        .bus_rdata_i   (bus_rdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .misalign_o    (misalign_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with DUT idle; acks after 'waits' extra REQ cycles (waits<0: never)
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rword, input int waits);
        mem_read_i  = rd;
        mem_write_i = wr;
        funct3_i    = f3;
        addr_i      = a;
        wdata_i     = wd;
        n_req = 0; n_stall = 0; n_valid = 0;
        s_mis = 1'b0; s_to = 1'b0; s_stable = 1'b1; s_done = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (stall_o) n_stall++;
            if (bus_req_o) begin
                if (n_req == 0) begin
                    snap_addr  = bus_addr_o;
                    snap_be    = bus_be_o;
                    snap_we    = bus_we_o;
                    snap_wdata = bus_wdata_o;
                end else if (bus_addr_o !== snap_addr || bus_be_o !== snap_be ||
                             bus_we_o !== snap_we || bus_wdata_o !== snap_wdata) begin
                    s_stable = 1'b0;
                end
                n_req++;
                bus_ack_i   = (waits >= 0) && (n_req == waits + 1);
                bus_rdata_i = bus_ack_i ? rword : 32'h5A5A_5A5A;
            end else begin
                bus_ack_i   = 1'b0;
                bus_rdata_i = 32'h0;
            end
            if (n_stall > 0 && !stall_o) begin
                if (rdata_valid_o) n_valid++;
                s_mis   = misalign_o;
                s_to    = timeout_o;
                s_rdata = rdata_o;
                s_done  = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        bus_ack_i   = 1'b0;
        @(posedge clk);
        #1;
        s_post_busy = rdata_valid_o | misalign_o | timeout_o | stall_o | bus_req_o;
        check("access_ends", 32'(s_done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b0;
        addr_i = 32'h0; wdata_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   32'(bus_req_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_be",    32'(bus_be_o), 32'd0);
        check("rst_rdata", rdata_o, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_stall", 32'(stall_o), 32'd0);

        // LW 0x100, zero-wait ack
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        check("lw_nreq",   32'(n_req), 32'd1);
        check("lw_nstall", 32'(n_stall), 32'd2);
        check("lw_be",     32'(snap_be), 32'hF);
        check("lw_addr",   snap_addr, 32'h100);
        check("lw_we",     32'(snap_we), 32'd0);
        check("lw_valid",  32'(n_valid), 32'd1);
        check("lw_rdata",  s_rdata, 32'hDEADBEEF);
        check("lw_post",   32'(s_post_busy), 32'd0);
        check("lw_hold",   rdata_o, 32'hDEADBEEF);

        // LB / LBU 0x103
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 0);
        check("lb_be",     32'(snap_be), 32'h8);
        check("lb_addr",   snap_addr, 32'h100);
        check("lb_rdata",  s_rdata, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h8000_0000, 0);
        check("lbu_rdata", s_rdata, 32'h0000_0080);

        // LB positive byte in lane 1, LH upper half negative
        run_access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h0000_7F00, 1);
        check("lb1_be",    32'(snap_be), 32'h2);
        check("lb1_rdata", s_rdata, 32'h0000_007F);
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 0);
        check("lh_be",     32'(snap_be), 32'hC);
        check("lh_rdata",  s_rdata, 32'hFFFF_8001);

        // SH 0x102 with 3 wait cycles
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 3);
        check("sh_nreq",   32'(n_req), 32'd4);
        check("sh_stable", 32'(s_stable), 32'd1);
        check("sh_be",     32'(snap_be), 32'hC);
        check("sh_wdata",  snap_wdata, 32'hABCD_ABCD);
        check("sh_we",     32'(snap_we), 32'd1);
        check("sh_valid",  32'(n_valid), 32'd0);
        check("sh_rhold",  s_rdata, 32'hFFFF_8001);

        // Read and write both set acts as SB
        run_access(1'b1, 1'b1, 3'b000, 32'h001, 32'h0000_00A5, 32'h0, 0);
        check("sb_we",     32'(snap_we), 32'd1);
        check("sb_be",     32'(snap_be), 32'h2);
        check("sb_wdata",  snap_wdata, 32'hA5A5_A5A5);
        check("sb_valid",  32'(n_valid), 32'd0);

        // Misaligned LW and illegal size
        run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        check("mis_nreq",   32'(n_req), 32'd0);
        check("mis_nstall", 32'(n_stall), 32'd1);
        check("mis_flag",   32'(s_mis), 32'd1);
        check("mis_rdata",  s_rdata, 32'hFFFF_8001);
        check("mis_post",   32'(s_post_busy), 32'd0);
        run_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        check("ill_nreq",  32'(n_req), 32'd0);
        check("ill_flag",  32'(s_mis), 32'd1);
        run_access(1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 32'h0, 0);
        check("mish_flag", 32'(s_mis), 32'd1);

        // Timeout, then a normal access
        run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, -1);
        check("to_nreq",   32'(n_req), 32'd15);
        check("to_nstall", 32'(n_stall), 32'd16);
        check("to_flag",   32'(s_to), 32'd1);
        check("to_mis",    32'(s_mis), 32'd0);
        check("to_valid",  32'(n_valid), 32'd0);
        check("to_rdata",  s_rdata, 32'hFFFF_8001);
        check("to_post",   32'(s_post_busy), 32'd0);
        run_access(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'h0123_4567, 1);
        check("after_nreq",  32'(n_req), 32'd2);
        check("after_rdata", s_rdata, 32'h0123_4567);

        // Reset in the second REQ cycle, then ack after release is ignored
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rr_req_pre", 32'(bus_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rr_req",   32'(bus_req_o), 32'd0);
        check("rr_stall", 32'(stall_o), 32'd0);
        check("rr_be",    32'(bus_be_o), 32'd0);
        check("rr_addr",  bus_addr_o, 32'h0);
        check("rr_rdata", rdata_o, 32'h0);
        mem_read_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rr_ack_req",   32'(bus_req_o), 32'd0);
            check("rr_ack_valid", 32'(rdata_valid_o), 32'd0);
            check("rr_ack_rdata", rdata_o, 32'h0);
        end
        bus_ack_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
